// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// decoder/mux slice.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_OKAY = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped regions: zero-wait OKAY for idle/busy, two-cycle
// ERROR for active transfers. State is exported for checkers.
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      hready,
   input  logic      unmapped_active,
   output logic      hreadyout,
   output logic      hresp,
   output ds_state_e state
);

   ds_state_e state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DS_OKAY;
      else        state_q <= state_d;
   end

   // ERR1 always completes; otherwise the next state is chosen only when the
   // bus samples an address phase, so mapped-slave stalls keep us in OKAY.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DS_ERR1: state_d = DS_ERR2;
         default: if (hready) state_d = unmapped_active ? DS_ERR1 : DS_OKAY;
      endcase
   end

   always_comb begin
      hreadyout = (state_q != DS_ERR1);
      hresp     = (state_q == DS_OKAY) ? HRESP_OKAY : HRESP_ERROR;
   end

   assign state = state_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer with a built-in default
// slave and a saturating decode-error counter.
module ahb_decoder_mux
   import ahb_pkg::*;
#(
   parameter int NUM_SLAVES  = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int REGION_BITS = 4,
   parameter int CNT_W       = 8
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [ADDR_W-1:0]            HADDR,
   input  logic [1:0]                   HTRANS,
   output logic [NUM_SLAVES-1:0]        HSEL,
   input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]        HRESP_S,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic [CNT_W-1:0]             DEC_ERR_CNT,
   input  logic                         DEC_ERR_CLR
);

   localparam logic [REGION_BITS-1:0] NUM_SLAVES_R = REGION_BITS'(NUM_SLAVES);

   logic [REGION_BITS-1:0] region;
   logic                   mapped;
   logic                   unmapped_active;
   logic [REGION_BITS-1:0] dsel_idx;
   logic                   dsel_def;
   logic                   ds_ready;
   logic                   ds_resp;
   ds_state_e              ds_state;
   logic                   unused_ok;

   assign region          = HADDR[ADDR_W-1 -: REGION_BITS];
   assign mapped          = (region < NUM_SLAVES_R);
   assign unmapped_active = !mapped && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign unused_ok       = ^{HADDR[ADDR_W-REGION_BITS-1:0], ds_state};

   always_comb begin
      HSEL = '0;
      for (int i = 0; i < NUM_SLAVES; i++) HSEL[i] = (region == REGION_BITS'(i));
   end

   // Handshake: HREADY=1 marks the current address phase as accepted and the
   // current data phase as complete; HREADY=0 holds both, so dsel and the
   // error counter only move on cycles where HREADY=1.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_def <= 1'b1;
         dsel_idx <= '0;
      end else if (HREADY) begin
         dsel_def <= !mapped;
         dsel_idx <= region;
      end
   end

   ahb_default_slave u_default_slave (
      .clk             (HCLK),
      .rst_n           (HRESETn),
      .hready          (HREADY),
      .unmapped_active (unmapped_active),
      .hreadyout       (ds_ready),
      .hresp           (ds_resp),
      .state           (ds_state)
   );

   always_comb begin
      HRDATA = '0;
      HREADY = ds_ready;
      HRESP  = ds_resp;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!dsel_def && dsel_idx == REGION_BITS'(i)) begin
            HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i];
         end
      end
   end

   // An accepted unmapped active transfer is exactly the entry into ERR1.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                            DEC_ERR_CNT <= '0;
      else if (DEC_ERR_CLR)                    DEC_ERR_CNT <= '0;
      else if (HREADY && unmapped_active && DEC_ERR_CNT != '1)
                                               DEC_ERR_CNT <= DEC_ERR_CNT + CNT_W'(1);
   end

endmodule
